// File: rtl/alu_proto_pkg.sv
// Shared protocol definitions for the FP ALU host and the byte-serial ALU
// it drives. The host walks through the states below once per request. The
// ALU is given two operands of OPERAND_BYTES each, sent one byte at a time.
// It returns an OPERAND_BYTES result, also one byte at a time.
package alu_proto_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RECV      = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

  localparam int   OPERAND_BYTES = 4;
  localparam int   SEND_BYTES    = 2 * OPERAND_BYTES;
  localparam logic OP_ADD        = 1'b0;
  localparam logic OP_SUB        = 1'b1;

  // Byte idx of the outgoing operand word, LSB first.
  function automatic logic [7:0] pick_byte(
    input logic [8*SEND_BYTES-1:0]         word,
    input logic [$clog2(SEND_BYTES)-1:0]   idx
  );
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/alu_byte_collector.sv
// Result capture register for the byte-serial ALU.
// Bytes arrive LSB first. Each capture writes the slot under the index
// counter and then advances the counter.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr_i     - clear the result register and the index (new transaction)
//   cap_i     - capture byte_i into slot idx_o and advance the index
//   byte_i    - incoming result byte
//   idx_o     - slot that the next capture will write
//   data_o    - assembled result word
module alu_byte_collector
  import alu_proto_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr_i,
  input  logic                              cap_i,
  input  logic [7:0]                        byte_i,
  output logic [$clog2(OPERAND_BYTES)-1:0]  idx_o,
  output logic [8*OPERAND_BYTES-1:0]        data_o
);
  localparam int IW = $clog2(OPERAND_BYTES);

  logic [IW-1:0]              idx_q, idx_d;
  logic [8*OPERAND_BYTES-1:0] data_q, data_d;

  always_comb begin
    idx_d  = idx_q;
    data_d = data_q;
    if (clr_i) begin
      idx_d  = '0;
      data_d = '0;
    end else if (cap_i) begin
      data_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d                        = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

  assign idx_o  = idx_q;
  assign data_o = data_q;

endmodule

// File: rtl/fp_alu_host.sv
// Host adapter between a 32-bit FP add/sub request port and a byte-serial ALU.
// Each accepted request follows this sequence:
//   1. Pulse alu_start for one cycle.
//   2. Stream A then B to the ALU, LSB first.
//   3. Wait up to TIMEOUT_CYCLES for alu_done.
//   4. Collect 4 result bytes on consecutive alu_done cycles.
//   5. Hold the response until rsp_ready is sampled high.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   req_valid/req_ready        - request handshake (ready only in IDLE)
//   req_a, req_b, req_op       - FP32 operands, 0 = add, 1 = subtract
//   rsp_valid/rsp_ready        - response handshake
//   rsp_result, rsp_error      - assembled result, timeout/protocol error flag
//   alu_in, alu_opcode, alu_start - byte bus, opcode and start pulse to ALU
//   alu_out, alu_done          - result byte bus and strobe from ALU
//   busy                       - high whenever a transaction is in flight
module fp_alu_host
  import alu_proto_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_error,
  output logic [7:0]  alu_in,
  output logic        alu_opcode,
  output logic        alu_start,
  input  logic [7:0]  alu_out,
  input  logic        alu_done,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SEND_BYTES);
  localparam int IW = $clog2(OPERAND_BYTES);

  state_e                     state_q, state_d;
  logic [31:0]                a_q, a_d, b_q, b_d;
  logic                       op_q, op_d;
  logic [SW-1:0]              sidx_q, sidx_d;
  logic [TW-1:0]              tcnt_q, tcnt_d;
  logic                       err_q, err_d;
  logic                       coll_clr, coll_cap;
  logic [IW-1:0]              coll_idx;
  logic [8*OPERAND_BYTES-1:0] coll_data;

  alu_byte_collector u_collector (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (coll_clr),
    .cap_i  (coll_cap),
    .byte_i (alu_out),
    .idx_o  (coll_idx),
    .data_o (coll_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      sidx_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sidx_q  <= sidx_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sidx_d   = sidx_q;
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    coll_clr = 1'b0;
    coll_cap = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d      = req_a;
          b_d      = req_b;
          op_d     = req_op;
          err_d    = 1'b0;
          // The previous result is wiped here so that a timeout reports zero.
          coll_clr = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        sidx_d  = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (sidx_q == SW'(SEND_BYTES - 1)) begin
          tcnt_d  = '0;
          state_d = ST_WAIT_DONE;
        end else begin
          sidx_d = sidx_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (alu_done) begin
          coll_cap = 1'b1;
          state_d  = ST_RECV;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_RECV: begin
        // Result bytes must arrive back to back. A gap ends the transaction
        // and the bytes captured so far are kept.
        if (alu_done) begin
          coll_cap = 1'b1;
          if (coll_idx == IW'(OPERAND_BYTES - 1)) state_d = ST_RESP;
        end else begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    alu_start  = (state_q == ST_START);
    alu_in     = 8'h00;
    if (state_q == ST_SEND) alu_in = pick_byte({b_q, a_q}, sidx_q);
    alu_opcode = 1'b0;
    if (state_q inside {ST_START, ST_SEND, ST_WAIT_DONE, ST_RECV}) alu_opcode = op_q;
    rsp_valid  = (state_q == ST_RESP);
    rsp_result = rsp_valid ? coll_data : 32'h0;
    rsp_error  = rsp_valid & err_q;
  end

endmodule

// File: tb/tb_fp_alu_host.sv
module tb_fp_alu_host;
  import alu_proto_pkg::*;

  localparam int TO = 16;
  localparam int M_NORM = 0, M_DROP = 1, M_NODONE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_error;
  logic [31:0] rsp_result;
  logic [7:0]  alu_in;
  logic        alu_opcode, alu_start, busy;
  logic [7:0]  alu_out = 8'h00;
  logic        alu_done = 1'b0;

  fp_alu_host #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .alu_in(alu_in), .alu_opcode(alu_opcode),
    .alu_start(alu_start), .alu_out(alu_out), .alu_done(alu_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Integer <-> FP32 conversion, exact for |v| < 2^23.
  function automatic logic [31:0] int_to_f32(input int v);
    int mag, p;
    logic s;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    s   = (v < 0);
    mag = s ? -v : v;
    p   = 0;
    for (int i = 0; i < 31; i++) if ((mag >> i) != 0) p = i;
    m = 32'(mag) << (23 - p);
    return {s, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int f32_to_int(input logic [31:0] f);
    int p, mag;
    if (f[30:23] == 8'h0) return 0;
    p = int'(f[30:23]) - 127;
    if (p < 0 || p > 23) return 0;
    mag = int'({1'b1, f[22:0]} >> (23 - p));
    return f[31] ? -mag : mag;
  endfunction

  // Reference model. delay is the number of idle WAIT_DONE cycles the ALU
  // inserts before its first result byte.
  task automatic ref_model(input int x, input int y, input logic op, input int mode,
                           input int delay, output logic [31:0] res,
                           output logic err, output int lat);
    logic [31:0] full;
    full = int_to_f32(op ? x - y : x + y);
    case (mode)
      M_NORM:  begin res = full;                err = 1'b0; lat = 13 + delay; end
      M_DROP:  begin res = {24'h0, full[7:0]};  err = 1'b1; lat = 11 + delay; end
      default: begin res = 32'h0;               err = 1'b1; lat = 9 + TO;     end
    endcase
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        op;
    logic [31:0] res;
    logic        err;
    int          lat, acc, hold;
  } exp_t;

  typedef struct { int mode; int delay; } alu_cfg_t;

  exp_t     sb[$];
  alu_cfg_t mq[$];
  bit       noise_en = 1'b0;

  // Byte-serial ALU responder. It collects 8 bytes after alu_start.
  // Then it waits cfg.delay cycles and returns 4 result bytes, LSB first.
  logic [63:0] rx_word = '0;
  int          ph = 0, acnt = 0;
  alu_cfg_t    cfg;
  logic [31:0] ares = '0;
  always @(negedge clk) begin
    if (rst) begin
      ph = 0; alu_done = 1'b0; alu_out = 8'h00;
    end else if (alu_start) begin
      cfg = (mq.size() > 0) ? mq.pop_front() : '{M_NORM, 1};
      ph = 1; acnt = 0; rx_word = '0;
      alu_done = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      alu_out  = 8'($urandom);
    end else begin
      case (ph)
        0: begin
          alu_done = (noise_en && !busy) ? 1'($urandom_range(0, 1)) : 1'b0;
          alu_out  = 8'($urandom);
        end
        1: begin
          rx_word[acnt*8 +: 8] = alu_in;
          acnt++;
          alu_done = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
          alu_out  = 8'($urandom);
          if (acnt == 8) begin
            ares = int_to_f32(alu_opcode == OP_SUB ?
                              f32_to_int(rx_word[31:0]) - f32_to_int(rx_word[63:32]) :
                              f32_to_int(rx_word[31:0]) + f32_to_int(rx_word[63:32]));
            acnt = 0; ph = 2; alu_done = 1'b0;
          end
        end
        2: begin
          alu_done = 1'b0;
          if (cfg.mode != M_NODONE) begin
            if (acnt == cfg.delay) begin
              alu_done = 1'b1; alu_out = ares[7:0]; acnt = 1; ph = 3;
            end else acnt++;
          end
        end
        default: begin
          if (cfg.mode == M_DROP || acnt == 4) begin
            alu_done = 1'b0; alu_out = 8'h00; ph = 0;
          end else begin
            alu_out = ares[acnt*8 +: 8]; acnt++;
          end
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on each rsp_valid rising edge, checks the
  // held response, and drives rsp_ready after the requested backpressure.
  exp_t        cur;
  bit          prev_valid = 0, prev_start = 0, released = 0;
  int          vcnt = 0;
  logic [31:0] held_res;
  logic        held_err;
  always @(negedge clk) begin
    if (rst) begin
      rsp_ready = 1'b0; vcnt = 0; prev_valid = 0; prev_start = 0; released = 0;
    end else begin
      if (released) begin
        chk("idle_after_ready_busy", busy, 0);
        chk("idle_after_ready_req_ready", req_ready, 1);
        released = 0;
      end
      if (alu_start) begin
        chk("start_alu_in", alu_in, 8'h00);
        chk("start_single_pulse", prev_start, 0);
      end
      prev_start = alu_start;
      if (!busy) chk("idle_opcode", alu_opcode, 0);
      else if (!rsp_valid && sb.size() > 0) chk("opcode_held", alu_opcode, sb[0].op);
      if (rsp_valid) begin
        if (!prev_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp_valid", rsp_valid, 0);
            cur = '{default: '0};
          end else begin
            cur = sb.pop_front();
            chk("rsp_result", rsp_result, cur.res);
            chk("rsp_error", rsp_error, cur.err);
            chk("latency", cyc - cur.acc, cur.lat);
            chk("alu_in_sequence", rx_word, {cur.b, cur.a});
          end
          held_res = rsp_result;
          held_err = rsp_error;
          vcnt = 0;
        end else begin
          chk("rsp_result_stable", rsp_result, held_res);
          chk("rsp_error_stable", rsp_error, held_err);
        end
        chk("resp_req_ready_low", req_ready, 0);
        vcnt++;
        rsp_ready = (vcnt > cur.hold);
        if (rsp_ready) released = 1;
      end else begin
        rsp_ready = 1'b0;
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input int mode, input int delay, input int hold,
                       input logic [31:0] eres, input logic eerr, input int elat,
                       input bit expect_rsp);
    int n;
    n = 0;
    @(negedge clk);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_now("req_ready_wait");
      req_valid = 1'b0;
      return;
    end
    mq.push_back('{mode, delay});
    if (expect_rsp) sb.push_back('{a, b, op, eres, eerr, elat, cyc + 1, hold});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic issue_int(input int x, input int y, input logic op, input int mode,
                           input int delay, input int hold);
    logic [31:0] r;
    logic e;
    int l;
    ref_model(x, y, op, mode, delay, r, e, l);
    issue(int_to_f32(x), int_to_f32(y), op, mode, delay, hold, r, e, l, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) fail_now("drain");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_alu_start", alu_start, 0);
    chk("reset_alu_in", alu_in, 8'h00);
    chk("reset_alu_opcode", alu_opcode, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_error", rsp_error, 0);
    chk("reset_rsp_result", rsp_result, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);

    // 1.0 + 2.0, then 3.0 - 1.0, with the nominal one-cycle ALU.
    issue(32'h3F800000, 32'h40000000, OP_ADD, M_NORM, 1, 0, 32'h40400000, 1'b0, 14, 1'b1);
    issue(32'h40400000, 32'h3F800000, OP_SUB, M_NORM, 1, 0, 32'h40000000, 1'b0, 14, 1'b1);
    // ALU never answers.
    issue(32'h3F800000, 32'h40000000, OP_ADD, M_NODONE, 0, 0, 32'h0, 1'b1, 9 + TO, 1'b1);
    // Response held off for 5 cycles.
    issue(32'h40400000, 32'h3F800000, OP_ADD, M_NORM, 1, 5, 32'h40800000, 1'b0, 14, 1'b1);
    // 8388000 + 607 = 8388607 (0x4AFFFFFE). The ALU drops done after byte 0.
    issue(32'h4AFFFB40, 32'h4417C000, OP_ADD, M_DROP, 1, 0, 32'h000000FE, 1'b1, 12, 1'b1);
    drain();

    // Reset while the fifth operand byte (B LSB) is on the bus.
    issue(32'h11223344, 32'h55667788, OP_SUB, M_NORM, 1, 0, 32'h0, 1'b0, 0, 1'b0);
    repeat (6) @(negedge clk);
    chk("send_idx4_alu_in", alu_in, 8'h88);
    chk("send_idx4_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_alu_start", alu_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_alu_in", alu_in, 8'h00);
    chk("midrst_alu_opcode", alu_opcode, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_req_ready", req_ready, 1);
    issue(32'h3F800000, 32'h40000000, OP_ADD, M_NORM, 1, 0, 32'h40400000, 1'b0, 14, 1'b1);
    drain();

    noise_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      int x, y, mode, d, h, r;
      logic op;
      x  = int'($urandom_range(0, 8000000)) - 4000000;
      y  = int'($urandom_range(0, 8000000)) - 4000000;
      op = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      mode = (r == 0) ? M_DROP : (r == 1) ? M_NODONE : M_NORM;
      d  = $urandom_range(0, 4);
      h  = $urandom_range(0, 3);
      issue_int(x, y, op, mode, d, h);
    end
    drain();
    noise_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
